// File: rtl/bram_client_pkg.sv
// Shared types and constants for BRAM client blocks.
package bram_client_pkg;

    typedef enum logic [1:0] {IDLE, INIT, STREAM, DRAIN} bram_state_e;

    localparam int BRAM_READ_LATENCY = 1;
    localparam int RESP_DATA_W       = 32;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic                   last;
    } resp_t;

endpackage

// File: rtl/bram_resp_fifo.sv
// Small response FIFO holding returned BRAM words until the consumer takes them.
// Push and pop in the same cycle are allowed, including when full.
module bram_resp_fifo
    import bram_client_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = resp_t
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] occ_q;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= bump(wr_q);
            end
            if (pop_i) rd_q <= bump(rd_q);
            occ_q <= occ_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Turns a (base, count) command into a valid/ready stream of BRAM read data.
// Define BRAM_STREAM_READER_INIT_EN to zero-fill the BRAM after every reset.
module bram_stream_reader
    import bram_client_pkg::*;
#(
    parameter int dataSize  = 32,
    parameter int addrSize  = 9,
    parameter int numRows   = 512,
    parameter int fifoDepth = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [addrSize-1:0] cmd_base,
    input  logic [addrSize:0]   cmd_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [dataSize-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                bram_readEnable,
    output logic [addrSize-1:0] bram_readAddr,
    input  logic                bram_readReady,
    input  logic [dataSize-1:0] bram_readData,
    output logic                bram_writeEnable,
    output logic [addrSize-1:0] bram_writeAddr,
    output logic [dataSize-1:0] bram_writeData
);
    typedef struct packed {
        logic [dataSize-1:0] data;
        logic                last;
    } entry_t;

    localparam int                  CW       = $clog2(fifoDepth + 1);
    localparam logic [addrSize-1:0] LAST_ROW = addrSize'(numRows - 1);
`ifdef BRAM_STREAM_READER_INIT_EN
    localparam bram_state_e RESET_STATE = INIT;
`else
    localparam bram_state_e RESET_STATE = IDLE;
`endif

    bram_state_e         state_q;
    logic                cmd_ready_q, inflight_q, last_q;
    logic [addrSize-1:0] addr_q, addr_d;
    logic [addrSize:0]   count_q, issued_q, issued_d;
    logic                issue, final_issue, pop, fifo_empty;
    logic [CW-1:0]       fifo_occ;
    entry_t              head;
`ifdef BRAM_STREAM_READER_INIT_EN
    logic [addrSize-1:0] init_addr_q;
`endif

    // Credit check: a read may only go out if its word is guaranteed a FIFO slot.
    assign pop         = out_valid && out_ready;
    assign issue       = RST_N && (state_q == STREAM) && (issued_q < count_q) && bram_readReady
                         && ((int'(fifo_occ) + int'(inflight_q)) < (fifoDepth + int'(pop)));
    assign issued_d    = issued_q + 1'b1;
    assign final_issue = issue && (issued_d == count_q);
    assign addr_d      = (addr_q == LAST_ROW) ? '0 : addr_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= RESET_STATE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
`ifdef BRAM_STREAM_READER_INIT_EN
            init_addr_q <= '0;
`endif
        end else begin
            inflight_q <= issue;
            last_q     <= final_issue;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q && cmd_count != '0) begin
                        addr_q      <= cmd_base;
                        count_q     <= cmd_count;
                        issued_q    <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        addr_q   <= addr_d;
                        issued_q <= issued_d;
                        if (final_issue) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight_q && fifo_empty) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
`ifdef BRAM_STREAM_READER_INIT_EN
                INIT: begin
                    if (init_addr_q == LAST_ROW) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    bram_resp_fifo #(
        .DEPTH   (fifoDepth),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .push_i      (inflight_q),
        .push_data_i ('{data: bram_readData, last: last_q}),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .occ_o       (fifo_occ)
    );

    assign cmd_ready       = cmd_ready_q;
    assign busy            = RST_N && (state_q != IDLE);
    assign out_valid       = RST_N && !fifo_empty;
    assign out_data        = out_valid ? head.data : '0;
    assign out_last        = out_valid && head.last;
    assign bram_readEnable = issue;
    assign bram_readAddr   = addr_q;

`ifdef BRAM_STREAM_READER_INIT_EN
    assign bram_writeEnable = RST_N && (state_q == INIT);
    assign bram_writeAddr   = init_addr_q;
    assign bram_writeData   = '0;
`else
    assign bram_writeEnable = 1'b0;
    assign bram_writeAddr   = '0;
    assign bram_writeData   = '0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural one-cycle BRAM.
module tb_bram_stream_reader;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [8:0]  cmd_base = '0;
    logic [9:0]  cmd_count = '0;
    logic        out_valid, out_ready = 1'b1, out_last, busy;
    logic [31:0] out_data;
    logic        bram_readEnable, bram_readReady = 1'b1;
    logic [8:0]  bram_readAddr, bram_writeAddr;
    logic [31:0] bram_readData = '0, bram_writeData;
    logic        bram_writeEnable;

    logic [31:0] mem [512];
    logic        fill_req = 1'b1, clr = 1'b0, zeroed = 1'b0;
    int          cyc_now = 0;
    logic [32:0] beats [$];
    logic [8:0]  iss_addr [$];
    int          iss_cyc [$];
    int          outst = 0, maxout = 0, wr_cnt = 0, wr_bad = 0;
    int          checks = 0, errors = 0;

    bram_stream_reader dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_count(cmd_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy),
        .bram_readEnable(bram_readEnable), .bram_readAddr(bram_readAddr),
        .bram_readReady(bram_readReady), .bram_readData(bram_readData),
        .bram_writeEnable(bram_writeEnable), .bram_writeAddr(bram_writeAddr),
        .bram_writeData(bram_writeData)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [31:0] mval(input int a);
        return 32'h5A5A_0000 | 32'(a);
    endfunction

    function automatic int delta();
        return int'(bram_readEnable) - int'(out_valid && out_ready);
    endfunction

    always @(posedge CLK) begin
        if (fill_req) begin
            for (int i = 0; i < 512; i++) mem[i] <= mval(i);
        end else if (bram_writeEnable) begin
            mem[bram_writeAddr] <= bram_writeData;
        end
        if (bram_readEnable && bram_readReady) bram_readData <= mem[bram_readAddr];
    end

    // Reads issued minus beats taken = words held in FIFO plus the one in flight.
    always @(negedge CLK) begin
        if (clr) begin
            beats.delete(); iss_addr.delete(); iss_cyc.delete();
            outst <= 0; maxout <= 0;
        end else if (!RST_N) begin
            outst <= 0;
        end else begin
            if (bram_readEnable) begin
                iss_addr.push_back(bram_readAddr);
                iss_cyc.push_back(cyc_now);
            end
            if (out_valid && out_ready) beats.push_back({out_last, out_data});
            outst <= outst + delta();
            if (outst + delta() > maxout) maxout <= outst + delta();
        end
        if (RST_N && bram_writeEnable) begin
            wr_cnt <= wr_cnt + 1;
            if (bram_writeData != 0) wr_bad <= wr_bad + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int w;
        w = 0;
        while (!cmd_ready && w < budget) begin tick(); w++; end
        chk("wait_ready", cmd_ready, 1);
    endtask

    // bp=1 drives out_ready 1,0,0,1 repeating; read port stalls in cycles st_lo..st_hi.
    task automatic run_cmd(input int base, input int cnt, input int bp,
                           input int st_lo, input int st_hi, output int cyc);
        logic        stalled;
        logic [31:0] held;
        out_ready = 1'b1; bram_readReady = 1'b1; cyc_now = 0;
        cmd_valid = 1'b1; cmd_base = 9'(base); cmd_count = 10'(cnt);
        #1;
        wait_ready(2000);
        clr = 1'b1;
        tick();
        cmd_valid = 1'b0; clr = 1'b0;
        cyc = 0; stalled = 1'b0; held = '0;
        while (!cmd_ready && cyc < 2000) begin
            cyc++;
            cyc_now = cyc;
            bram_readReady = !(cyc >= st_lo && cyc <= st_hi);
            out_ready = (bp == 0) || (cyc % 4 == 1) || (cyc % 4 == 0);
            #1;
            if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
            stalled = out_valid && !out_ready;
            held = out_data;
            tick();
        end
        out_ready = 1'b1; bram_readReady = 1'b1;
        chk("cmd_done", cyc < 2000, 1);
    endtask

    task automatic verify(input string tag, input int base, input int cnt, input logic zero);
        int bad_b, bad_a, a;
        logic [32:0] e;
        bad_b = 0; bad_a = 0;
        chk({tag, "_nbeats"}, beats.size(), cnt);
        chk({tag, "_nissue"}, iss_addr.size(), cnt);
        for (int i = 0; i < cnt && i < beats.size(); i++) begin
            a = (base + i) % 512;
            e = {(i == cnt - 1), (zero ? 32'h0 : mval(a))};
            if (beats[i] !== e) bad_b++;
        end
        for (int i = 0; i < cnt && i < iss_addr.size(); i++)
            if (iss_addr[i] !== 9'((base + i) % 512)) bad_a++;
        chk({tag, "_data"}, bad_b, 0);
        chk({tag, "_addr"}, bad_a, 0);
        chk({tag, "_outst_le2"}, maxout <= 2, 1);
    endtask

    initial begin
        int c, n;
        repeat (3) tick();
        fill_req = 1'b0;
        chk("rst_ctl", {cmd_ready, out_valid, out_last, busy, bram_readEnable, bram_writeEnable}, 0);
        chk("rst_data", {out_data, bram_writeData}, 0);
        chk("rst_addr", {bram_readAddr, bram_writeAddr}, 0);
        RST_N = 1'b1;
        tick();
`ifdef BRAM_STREAM_READER_INIT_EN
        chk("init_busy", {busy, cmd_ready, bram_writeEnable}, 3'b101);
        wait_ready(1000);
        chk("init_writes", wr_cnt, 512);
        chk("init_zero", wr_bad, 0);
        run_cmd(0, 4, 0, 0, 0, c);
        verify("init_read", 0, 4, 1'b1);
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
`endif
        wait_ready(20);

        // single beat with exact latency
        clr = 1'b1; cmd_valid = 1'b1; cmd_base = 9'd5; cmd_count = 10'd1;
        #1 chk("t1_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; clr = 1'b0;
        chk("t1_c1_issue", {bram_readEnable, bram_readAddr}, {1'b1, 9'd5});
        chk("t1_c1_busy", {busy, cmd_ready}, 2'b10);
        tick();
        chk("t1_c2_novalid", out_valid, 0);
        tick();
        chk("t1_c3_beat", {out_valid, out_last, out_data}, {2'b11, mval(5)});
        tick();
        chk("t1_c4_drain", {out_valid, busy}, 2'b01);
        tick();
        chk("t1_c5_idle", {busy, cmd_ready}, 2'b01);

        run_cmd(510, 4, 0, 0, 0, c);
        chk("wrap_cycles", c, 7);
        verify("wrap", 510, 4, 1'b0);

        run_cmd(100, 8, 1, 0, 0, c);
        verify("bp", 100, 8, 1'b0);

        run_cmd(40, 6, 0, 2, 4, c);
        chk("stall_cycles", c, 12);
        verify("stall", 40, 6, 1'b0);
        chk("stall_first_issue", iss_cyc.size() > 0 ? iss_cyc[0] : -1, 1);
        n = 0;
        foreach (iss_cyc[i]) if (iss_cyc[i] >= 2 && iss_cyc[i] <= 4) n++;
        chk("stall_no_issue", n, 0);

        run_cmd(7, 0, 0, 0, 0, c);
        chk("cnt0_cycles", c, 0);
        chk("cnt0_busy", busy, 0);
        verify("cnt0", 7, 0, 1'b0);

        run_cmd(0, 512, 0, 0, 0, c);
        chk("sweep_cycles", c, 515);
        verify("sweep", 0, 512, 1'b0);

        // reset after three beats of a ten-beat command
        wait_ready(20);
        clr = 1'b1; cmd_valid = 1'b1; cmd_base = 9'd20; cmd_count = 10'd10;
        tick();
        cmd_valid = 1'b0; clr = 1'b0;
        repeat (5) tick();
        chk("mid_beats", beats.size(), 3);
        RST_N = 1'b0;
        #1 chk("mid_rst_valid", {out_valid, bram_readEnable}, 0);
        tick();
        chk("mid_rst_state", {out_valid, busy, cmd_ready}, 0);
        tick();
        RST_N = 1'b1;
        #1 chk("mid_rel_valid", out_valid, 0);
        repeat (3) begin
            tick();
            chk("mid_post_valid", out_valid, 0);
        end
        chk("mid_total_beats", beats.size(), 3);
        n = 0;
        for (int i = 0; i < beats.size(); i++)
            if (beats[i] !== {(1'b0), mval(20 + i)}) n++;
        chk("mid_data", n, 0);
`ifdef BRAM_STREAM_READER_INIT_EN
        zeroed = 1'b1;
`endif
        run_cmd(300, 3, 0, 0, 0, c);
        chk("post_rst_cycles", c, 6);
        verify("post_rst", 300, 3, zeroed);

`ifdef BRAM_STREAM_READER_INIT_EN
        chk("write_total", wr_cnt, 1024);
`else
        chk("no_writes", wr_cnt, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
